// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream between the ROM reader and the layer datapath.
// The last tag exists only when ROM_STREAM_READER_LAST_EN is defined.
interface rom_stream_reader_if #(
    parameter int WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] data;
    logic                 valid;
    logic                 ready;
`ifdef ROM_STREAM_READER_LAST_EN
    logic                 last;
`endif

    modport master (
        output data,
        output valid,
`ifdef ROM_STREAM_READER_LAST_EN
        output last,
`endif
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
`ifdef ROM_STREAM_READER_LAST_EN
        input  last,
`endif
        output ready
    );
endinterface

// File: rtl/rom_stream_reader.sv
// Sweeps a 1-cycle-latency ROM and streams its words through a 2-entry skid FIFO.
// Optional last-word tag on the stream: define ROM_STREAM_READER_LAST_EN.
module rom_stream_reader #(
    parameter int ADDR_WIDTH = 3,
    parameter int WORD_SIZE  = 8,
    parameter int NUM_WORDS  = 2 ** ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [WORD_SIZE-1:0]  rom_data_i,
    rom_stream_reader_if.master   stream_o
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     iss_q, iss_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic                 infl_q, infl_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic [WORD_SIZE-1:0] mem_q [2];
`ifdef ROM_STREAM_READER_LAST_EN
    logic                 tag_q [2];
    logic                 tag_in;
`endif

    logic       issue;
    logic       push;
    logic       pop;
    logic [2:0] occ;

    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        acc_d   = acc_q;
        issue   = 1'b0;
        push    = infl_q;
        pop     = (cnt_q != 2'd0) && stream_o.ready;
        // occupancy seen by the next cycle if nothing new is issued
        occ     = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    iss_d   = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                issue = (iss_q < NUM_CNT) && (occ < 3'd2);
                if (issue) begin
                    iss_d = iss_q + CNT_W'(1);
                end
                if (pop) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        infl_d = issue;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        wr_d   = wr_q ^ push;
        rd_d   = rd_q ^ pop;
    end

`ifdef ROM_STREAM_READER_LAST_EN
    // the word being captured was issued last cycle, so iss_q is its index + 1
    assign tag_in = (iss_q == NUM_CNT);
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            iss_q    <= '0;
            acc_q    <= '0;
            infl_q   <= 1'b0;
            cnt_q    <= 2'd0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
`ifdef ROM_STREAM_READER_LAST_EN
            tag_q[0] <= 1'b0;
            tag_q[1] <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            acc_q   <= acc_d;
            infl_q  <= infl_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            if (push) begin
                mem_q[wr_q] <= rom_data_i;
`ifdef ROM_STREAM_READER_LAST_EN
                tag_q[wr_q] <= tag_in;
`endif
            end
        end
    end

    assign busy_o         = (state_q == S_RUN);
    assign done_o         = (state_q == S_DONE);
    assign rom_addr_o     = iss_q[ADDR_WIDTH-1:0];
    assign stream_o.valid = (cnt_q != 2'd0);
    assign stream_o.data  = mem_q[rd_q];
`ifdef ROM_STREAM_READER_LAST_EN
    assign stream_o.last  = (cnt_q != 2'd0) && tag_q[rd_q];
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: 8-word and 1-word instances.
// Build with ROM_STREAM_READER_LAST_EN to also check the last tag.
module tb_rom_stream_reader;
    localparam int AW = 3;
    localparam int WS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start0, start1, rdy0, rdy1;
    logic          busy0, done0, busy1, done1;
    logic [AW-1:0] addr0, addr1;
    logic [WS-1:0] rom0, rom1;

    rom_stream_reader_if #(.WORD_SIZE(WS)) s0 ();
    rom_stream_reader_if #(.WORD_SIZE(WS)) s1 ();
    assign s0.ready = rdy0;
    assign s1.ready = rdy1;

    rom_stream_reader #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .NUM_WORDS(8)) dut (
        .clk_i(clk), .reset_i(rst_n), .start_i(start0), .busy_o(busy0),
        .done_o(done0), .rom_addr_o(addr0), .rom_data_i(rom0), .stream_o(s0)
    );

    rom_stream_reader #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .NUM_WORDS(1)) dut1 (
        .clk_i(clk), .reset_i(rst_n), .start_i(start1), .busy_o(busy1),
        .done_o(done1), .rom_addr_o(addr1), .rom_data_i(rom1), .stream_o(s1)
    );

    // ROM model: data = 3*addr+1, one cycle latency
    always @(posedge clk) begin
        rom0 <= 8'(3 * int'(addr0) + 1);
        rom1 <= 8'(3 * int'(addr1) + 1);
    end

    int            nvec, nerr, cyc;
    int            hs_cnt, done_cnt, last_cnt, last_hs, done_cyc;
    int            h0, d0, l0;
    logic          prev_stall, pend;
    logic [WS-1:0] prev_data;
    logic [WS-1:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 8; i++) q.push_back(8'(3 * i + 1));
    endtask

    task automatic sample();
        logic [31:0] e;
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_valid", 32'(s0.valid), 1);
            chk("hold_data", 32'(s0.data), 32'(prev_data));
        end
`ifdef ROM_STREAM_READER_LAST_EN
        if (s0.valid) chk("last", 32'(s0.last), 32'(s0.data == 8'd22));
`endif
        if (s0.valid && rdy0) begin
            hs_cnt++;
            last_hs = cyc;
            e = (q.size() > 0) ? 32'(q.pop_front()) : 'x;
            chk("word", 32'(s0.data), e);
`ifdef ROM_STREAM_READER_LAST_EN
            if (s0.last) last_cnt++;
`endif
        end
        if (done0) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = s0.valid && !rdy0;
        prev_data  = s0.data;
    endtask

    initial begin
        nvec = 0; nerr = 0; cyc = 0;
        hs_cnt = 0; done_cnt = 0; last_cnt = 0; last_hs = -1; done_cyc = -1;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        rdy0 = 1'b1; rdy1 = 1'b0; prev_stall = 1'b0; prev_data = '0;

        tick(); tick(); sample();
        chk("rst_valid", 32'(s0.valid), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_addr", 32'(addr0), 0);
        chk("rst_data", 32'(s0.data), 0);
        chk("rst_valid1", 32'(s1.valid), 0);
        tick(); rst_n = 1'b1; sample();

        // sweep with ready held high
        cyc = -1;
        tick(); start0 = 1'b1; push_sweep(); sample();
        for (int c = 1; c <= 12; c++) begin
            tick(); start0 = 1'b0; sample();
            chk("t1_valid", 32'(s0.valid), 32'(cyc >= 3 && cyc <= 10));
            chk("t1_busy", 32'(busy0), 32'(cyc >= 1 && cyc <= 10));
            chk("t1_done", 32'(done0), 32'(cyc == 11));
        end
        chk("t1_left", q.size(), 0);

        // stall in cycles 4..7
        cyc = -1; done_cyc = -1;
        h0 = hs_cnt; d0 = done_cnt;
        tick(); start0 = 1'b1; push_sweep(); sample();
        for (int c = 1; c <= 40; c++) begin
            tick(); start0 = 1'b0; rdy0 = !(cyc >= 4 && cyc <= 7); sample();
            if (cyc >= 4 && cyc <= 7) begin
                chk("t2_valid", 32'(s0.valid), 1);
                chk("t2_data", 32'(s0.data), 4);
                chk("t2_addr", 32'(addr0), 3);
            end
        end
        chk("t2_words", 32'(hs_cnt - h0), 8);
        chk("t2_dones", 32'(done_cnt - d0), 1);
        chk("t2_done_lat", 32'(done_cyc), 32'(last_hs + 1));
        chk("t2_left", q.size(), 0);

        // start re-pulsed mid-sweep
        cyc = -1; h0 = hs_cnt; d0 = done_cnt;
        tick(); start0 = 1'b1; push_sweep(); sample();
        for (int c = 1; c <= 25; c++) begin
            tick(); start0 = (cyc == 5); sample();
        end
        chk("t3_words", 32'(hs_cnt - h0), 8);
        chk("t3_dones", 32'(done_cnt - d0), 1);
        chk("t3_left", q.size(), 0);

        // reset in cycle 6, then a fresh sweep
        cyc = -1;
        tick(); start0 = 1'b1; push_sweep(); sample();
        for (int c = 1; c <= 6; c++) begin
            tick(); start0 = 1'b0; rst_n = (cyc != 6); sample();
        end
        tick(); rst_n = 1'b1; q.delete(); prev_stall = 1'b0; sample();
        chk("t4_valid", 32'(s0.valid), 0);
        chk("t4_busy", 32'(busy0), 0);
        chk("t4_addr", 32'(addr0), 0);
        chk("t4_data", 32'(s0.data), 0);
        cyc = -1; h0 = hs_cnt; d0 = done_cnt;
        tick(); start0 = 1'b1; push_sweep(); sample();
        for (int c = 1; c <= 14; c++) begin
            tick(); start0 = 1'b0; sample();
            if (cyc == 3) chk("t4_first", 32'(s0.data), 1);
        end
        chk("t4_words", 32'(hs_cnt - h0), 8);
        chk("t4_dones", 32'(done_cnt - d0), 1);
        chk("t4_left", q.size(), 0);

        // single-word instance, ready low until cycle 9
        cyc = -1;
        tick(); start1 = 1'b1; rdy1 = 1'b0; sample();
        for (int c = 1; c <= 11; c++) begin
            tick(); start1 = 1'b0; rdy1 = (cyc >= 9); sample();
            chk("t5_valid", 32'(s1.valid), 32'(cyc >= 3 && cyc <= 9));
            if (cyc >= 3 && cyc <= 9) chk("t5_data", 32'(s1.data), 1);
            chk("t5_busy", 32'(busy1), 32'(cyc >= 1 && cyc <= 9));
            chk("t5_done", 32'(done1), 32'(cyc == 10));
        end

        // three back-to-back sweeps with random ready
        pend = 1'b1; h0 = hs_cnt; d0 = done_cnt; l0 = last_cnt;
        for (int n = 0; n < 400 && (done_cnt - d0) < 3; n++) begin
            tick();
            start0 = 1'b0;
            rdy0 = 1'($urandom_range(0, 1));
            if (pend) begin
                start0 = 1'b1;
                push_sweep();
                pend = 1'b0;
            end
            sample();
            if (done0 && (done_cnt - d0) < 3) pend = 1'b1;
        end
        rdy0 = 1'b1; start0 = 1'b0;
        chk("t6_dones", 32'(done_cnt - d0), 3);
        chk("t6_words", 32'(hs_cnt - h0), 24);
        chk("t6_left", q.size(), 0);
`ifdef ROM_STREAM_READER_LAST_EN
        chk("t6_lasts", 32'(last_cnt - l0), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
